// File: rtl/test007.sv
// Port I/O self-check block with two callable methods: test(t1,t2,t3) and run().
// One shared FSM serves both; each call holds its busy flag high for three cycles.
module test007 (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_din_exp,
   output logic        out_dout_exp,
   input  logic [15:0] in16_din_exp,
   output logic [15:0] out16_dout_exp,
   input  logic [31:0] in32_din_exp,
   output logic [31:0] out32_dout_exp,
   input  logic        test_t1,
   input  logic [15:0] test_t2,
   input  logic [31:0] test_t3,
   input  logic        test_req,
   output logic        test_busy,
   output logic        test_return,
   input  logic        run_req,
   output logic        run_busy
);

   typedef enum logic [2:0] {
      IDLE,
      T_EXEC,
      T_DONE,
      R_EXEC,
      R_DONE
   } state_t;

   state_t      state;
   logic        fin;
   logic        hit;
   logic        t1;
   logic [15:0] t2;
   logic [31:0] t3;
   logic        i1;
   logic [15:0] i16;
   logic [31:0] i32;

   // The DONE states take two cycles: the first registers the compare,
   // the second commits, giving three busy cycles per call.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         fin            <= 1'b0;
         hit            <= 1'b0;
         t1             <= 1'b0;
         t2             <= '0;
         t3             <= '0;
         i1             <= 1'b0;
         i16            <= '0;
         i32            <= '0;
         out_dout_exp   <= 1'b0;
         out16_dout_exp <= '0;
         out32_dout_exp <= '0;
         test_busy      <= 1'b0;
         test_return    <= 1'b0;
         run_busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               fin <= 1'b0;
               if (test_req) begin
                  test_busy <= 1'b1;
                  state     <= T_EXEC;
               end else if (run_req) begin
                  run_busy <= 1'b1;
                  state    <= R_EXEC;
               end
            end
            T_EXEC: begin
               t1    <= test_t1;
               t2    <= test_t2;
               t3    <= test_t3;
               i1    <= in_din_exp;
               i16   <= in16_din_exp;
               i32   <= in32_din_exp;
               state <= T_DONE;
            end
            T_DONE: begin
               if (!fin) begin
                  hit <= (i1 == t1) && (i16 == t2) && (i32 == t3);
                  fin <= 1'b1;
               end else begin
                  out_dout_exp   <= t1;
                  out16_dout_exp <= t2;
                  out32_dout_exp <= t3;
                  test_return    <= hit;
                  test_busy      <= 1'b0;
                  fin            <= 1'b0;
                  state          <= IDLE;
               end
            end
            R_EXEC: begin
               i1    <= in_din_exp;
               i16   <= in16_din_exp;
               i32   <= in32_din_exp;
               state <= R_DONE;
            end
            R_DONE: begin
               if (!fin) begin
                  fin <= 1'b1;
               end else begin
                  out_dout_exp   <= i1;
                  out16_dout_exp <= i16;
                  out32_dout_exp <= i32;
                  run_busy       <= 1'b0;
                  fin            <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_test007.sv
// Scoreboard bench for test007: expectations queued at call time,
// checked when the matching busy flag falls.
module tb_test007;

   logic        clk = 1'b0;
   logic        reset;
   logic        in1;
   logic [15:0] in16;
   logic [31:0] in32;
   logic        a1;
   logic [15:0] a2;
   logic [31:0] a3;
   logic        test_req;
   logic        run_req;
   logic        out1;
   logic [15:0] out16;
   logic [31:0] out32;
   logic        test_busy;
   logic        test_return;
   logic        run_busy;

   typedef struct {
      bit          is_test;
      logic        o1;
      logic [15:0] o16;
      logic [31:0] o32;
      logic        ret;
   } exp_t;

   exp_t sb[$];
   logic last_ret;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   test007 dut (
      .clk            (clk),
      .reset          (reset),
      .in_din_exp     (in1),
      .out_dout_exp   (out1),
      .in16_din_exp   (in16),
      .out16_dout_exp (out16),
      .in32_din_exp   (in32),
      .out32_dout_exp (out32),
      .test_t1        (a1),
      .test_t2        (a2),
      .test_t3        (a3),
      .test_req       (test_req),
      .test_busy      (test_busy),
      .test_return    (test_return),
      .run_req        (run_req),
      .run_busy       (run_busy)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(bit is_t);
      exp_t e;
      e.is_test = is_t;
      if (is_t) begin
         e.o1     = a1;
         e.o16    = a2;
         e.o32    = a3;
         last_ret = (in1 == a1) && (in16 == a2) && (in32 == a3);
      end else begin
         e.o1  = in1;
         e.o16 = in16;
         e.o32 = in32;
      end
      e.ret = last_ret;
      sb.push_back(e);
   endtask

   task automatic set_io(logic i1, logic [15:0] i16, logic [31:0] i32,
                         logic t1, logic [15:0] t2, logic [31:0] t3);
      in1  = i1;
      in16 = i16;
      in32 = i32;
      a1   = t1;
      a2   = t2;
      a3   = t3;
   endtask

   task automatic wait_busy(string tag);
      int n = 0;
      while ((test_busy || run_busy) && n < 12) begin
         n++;
         tick();
      end
      check(tag, n, 3);
   endtask

   task automatic call(bit is_t);
      push(is_t);
      if (is_t) test_req = 1'b1;
      else run_req = 1'b1;
      tick();
      check(is_t ? "t_busy_rise" : "r_busy_rise",
            is_t ? test_busy : run_busy, 1);
      test_req = 1'b0;
      run_req  = 1'b0;
      wait_busy(is_t ? "t_busy_len" : "r_busy_len");
   endtask

   task automatic compare(bit is_t);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("sb_kind", is_t, e.is_test);
         check("out1", out1, e.o1);
         check("out16", out16, e.o16);
         check("out32", out32, e.o32);
         check("ret", test_return, e.ret);
      end
   endtask

   // Monitor: runs after the driver's updates within each cycle.
   initial begin
      logic rs;
      logic pt = 1'b0;
      logic pr = 1'b0;
      forever begin
         @(posedge clk);
         rs = reset;
         #2;
         if (rs) begin
            pt = 1'b0;
            pr = 1'b0;
         end else begin
            check("overlap", test_busy & run_busy, 0);
            if (pt && !test_busy) compare(1'b1);
            if (pr && !run_busy) compare(1'b0);
            pt = test_busy;
            pr = run_busy;
         end
      end
   end

   initial begin
      reset    = 1'b1;
      test_req = 1'b0;
      run_req  = 1'b0;
      last_ret = 1'b0;
      set_io(1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
      repeat (6) tick();
      reset = 1'b0;
      tick();
      check("rst_out1", out1, 0);
      check("rst_out16", out16, 0);
      check("rst_out32", out32, 0);
      check("rst_ret", test_return, 0);
      check("rst_tbusy", test_busy, 0);
      check("rst_rbusy", run_busy, 0);

      // Held request: two back-to-back calls, 3 busy / 1 idle.
      set_io(1'b1, 16'd100, 32'd200, 1'b1, 16'd100, 32'd200);
      push(1'b1);
      push(1'b1);
      test_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("held_busy", test_busy, (i % 4) != 3);
      end
      test_req = 1'b0;
      tick();

      set_io(1'b1, 16'd100, 32'd201, 1'b1, 16'd100, 32'd200);
      call(1'b1);
      tick();
      set_io(1'b0, 16'd100, 32'd200, 1'b1, 16'd100, 32'd200);
      call(1'b1);
      tick();

      set_io(1'b0, 16'hABCD, 32'hDEADBEEF, 1'b1, 16'd1, 32'd2);
      call(1'b0);
      tick();

      // Simultaneous requests: test first, run after one idle cycle.
      set_io(1'b1, 16'h1234, 32'h5678_9ABC, 1'b1, 16'h1234, 32'h5678_9ABC);
      push(1'b1);
      push(1'b0);
      test_req = 1'b1;
      run_req  = 1'b1;
      tick();
      check("prio_t", test_busy, 1);
      check("prio_r", run_busy, 0);
      test_req = 1'b0;
      wait_busy("prio_t_len");
      check("gap_r", run_busy, 0);
      tick();
      run_req = 1'b0;
      check("prio_r_rise", run_busy, 1);
      wait_busy("prio_r_len");
      tick();

      // Reset in the middle of a test call aborts it.
      set_io(1'b1, 16'h00FF, 32'hFFFF0000, 1'b1, 16'h00FF, 32'hFFFF0000);
      test_req = 1'b1;
      tick();
      test_req = 1'b0;
      tick();
      check("mid_busy", test_busy, 1);
      reset = 1'b1;
      sb.delete();
      last_ret = 1'b0;
      tick();
      reset = 1'b0;
      check("mr_out1", out1, 0);
      check("mr_out16", out16, 0);
      check("mr_out32", out32, 0);
      check("mr_ret", test_return, 0);
      check("mr_tbusy", test_busy, 0);
      check("mr_rbusy", run_busy, 0);
      tick();
      call(1'b1);
      tick();
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/test007.md
# test007

Synthesijer-style method block exposing two callable methods, `test` and `run`, over req/busy handshakes, plus three input ports (1, 16 and 32 bit) and three registered output ports of the same widths. `test(t1, t2, t3)` drives the output ports with its arguments and returns true when every input port equals the corresponding argument. `run()` copies each input port to its output port. Used as a leaf port-I/O self-check block under a simulation harness or a host FSM.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_din_exp` in 1: flag input port.
- `out_dout_exp` out 1: flag output port, registered.
- `in16_din_exp` in 16: 16-bit input port.
- `out16_dout_exp` out 16: 16-bit output port, registered.
- `in32_din_exp` in 32: 32-bit input port.
- `out32_dout_exp` out 32: 32-bit output port, registered.
- `test_t1` in 1: argument t1 of `test`.
- `test_t2` in 16: argument t2 of `test`; the driver may connect a wider constant, only the low 16 bits are used.
- `test_t3` in 32: argument t3 of `test`.
- `test_req` in 1: call request for `test`, level-sampled.
- `test_busy` out 1: `test` in progress, registered.
- `test_return` out 1: boolean result of the last completed `test`, registered.
- `run_req` in 1: call request for `run`, level-sampled.
- `run_busy` out 1: `run` in progress, registered.

## Operation
- One shared FSM with states IDLE, T_EXEC, T_DONE, R_EXEC, R_DONE.
- IDLE:
  - `test_req`=1 → T_EXEC and `test_busy`←1.
  - Otherwise `run_req`=1 → R_EXEC and `run_busy`←1.
  - `test` has priority when both requests are high in the same cycle.
- T_EXEC: latch arguments and inputs, then → T_DONE.
  - t1/t2/t3 ← `test_t1`/`test_t2`/`test_t3`.
  - i1/i16/i32 ← `in_din_exp`/`in16_din_exp`/`in32_din_exp`.
- T_DONE, then → IDLE:
  - `out_dout_exp`←t1, `out16_dout_exp`←t2, `out32_dout_exp`←t3.
  - `test_return`←(i1==t1) && (i16==t2) && (i32==t3).
  - `test_busy`←0.
- R_EXEC: latch i1/i16/i32 from the inputs, then → R_DONE.
- R_DONE, then → IDLE:
  - Outputs ← i1/i16/i32.
  - `run_busy`←0.
  - `test_return` is unchanged.
- Comparisons are exact unsigned bitwise equality at the stated widths.
- A request arriving while the other method is active is not lost. Because requests are level-sampled, it is served on the next IDLE cycle if it is still high.
- A request that stays high re-invokes its method each time the FSM returns to IDLE.
- `test_return` holds its value between calls; it is valid whenever `test_busy`=0.

## Timing
- Reset, when `reset`=1 at a rising edge:
  - State → IDLE.
  - All outputs → 0: `out_dout_exp`, `out16_dout_exp`, `out32_dout_exp`, `test_return`, `test_busy`, `run_busy`.
  - Latched arguments and inputs are cleared.
  - Reset mid-call aborts the call; no result is produced.
- Request sampled high in IDLE at edge N → busy=1 after edge N.
- T_EXEC at N+1, T_DONE at N+2.
- After edge N+3, busy=0, and the outputs and `test_return` are updated.
- Call latency is 3 cycles from request sample to busy falling.
- Busy is high for 3 cycles.
- Inputs and arguments are sampled at edge N+1 (the T_EXEC/R_EXEC edge). Changes after that edge do not affect the current call.
- Minimum gap between calls is one IDLE cycle with both busy outputs low. Under a held request, busy shows 3 high cycles, then 1 low cycle, repeating.
- `test_busy` and `run_busy` are never high simultaneously.

## Test plan
- Reset for 6 cycles, then idle → all outputs 0, both busy 0.
- Inputs 1/100/200, args 1/100/200, raise and hold `test_req` → `test_busy` high within 1 cycle for 3 cycles. Then `test_return`=1, `out_dout_exp`=1, `out16_dout_exp`=100, `out32_dout_exp`=200.
- Same setup but `in32_din_exp`=201 → `test_return`=0. Repeat with only `in_din_exp`=0 → `test_return`=0.
- Inputs 0/0xABCD/0xDEADBEEF, pulse `run_req` for one cycle → `run_busy` high for 3 cycles. Outputs become 0/0xABCD/0xDEADBEEF; `test_return` unchanged.
- `test_req` and `run_req` raised in the same cycle → `test` executes first, `run` after one IDLE cycle. The busy outputs never overlap.
- Assert `reset` while `test_busy`=1 → next cycle all outputs 0, FSM idle. A following call with matching args returns 1.
